pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
- Parametrised, pipelined add/subtract unit. It is the sequential successor of the team's fixed-width 33-bit adder.
- Operands are split into CHUNK-bit slices. One slice is added per pipeline stage, with the carry registered between stages, so the critical path stays at one CHUNK-bit ripple regardless of N.
- Valid/ready handshake on both sides. The block sits between operand-producing datapaths and accumulator/ALU consumers.

Parameters:
- N, 33, operand and result width in bits (N >= 2).
- CHUNK, 11, bits added per stage (1 <= CHUNK <= N).
- STAGES, derived = ceil(N/CHUNK), pipeline depth. Not user-overridable. The last slice may be narrower than CHUNK.

Ports:
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operand beat present.
- in_ready, output, 1, block accepts a beat this cycle.
- x, input, N, operand A.
- y, input, N, operand B.
- sub, input, 1, 0 = x+y, 1 = x-y. Sampled with the beat.
- out_valid, output, 1, result beat present.
- out_ready, input, 1, consumer accepts the result.
- s, output, N, sum/difference modulo 2^N.
- cout, output, 1, carry out of bit N-1. For sub, 1 means no borrow (x >= y unsigned).
- ovf, output, 1, two's-complement signed overflow.

Behaviour:
- Reset (async assert, sync deassert by the user):
  - All stage valid bits cleared; out_valid=0.
  - s=0, cout=0, ovf=0, all carry registers 0.
  - in_ready=1 as soon as rst_n is high.
- Arithmetic:
  - Effective operand is yy = sub ? ~y : y, with initial carry-in = sub.
  - Stage k (0..STAGES-1) computes slice k = x[k] + yy[k] + c(k-1) and registers both the slice sum and the carry.
  - Operand slices above k travel down the pipeline in skew registers. Finished lower result slices are delayed in deskew registers, so all N result bits emerge aligned.
  - cout = carry out of the top slice.
  - ovf = (x[N-1] == yy[N-1]) && (s[N-1] != x[N-1]).
- Latency: a beat accepted at edge t produces out_valid=1 after edge t+STAGES-1 when there is no stall. For the defaults that is 3 cycles from acceptance to output.
- Throughput: one beat per cycle when out_ready=1.
- Handshake:
  - advance = !out_valid || out_ready.
  - in_ready = advance (combinational).
  - A beat transfers on in_valid && in_ready.
  - The output beat retires on out_valid && out_ready.
  - When advance=0, every stage register (data, carry, valid, skew) holds.
  - Bubbles propagate as valid=0 slots. They are not squeezed out.
  - While out_valid=1, s, cout and ovf stay stable until the beat retires.
- Simultaneous events: when a retire and an accept happen in the same cycle, both occur and the pipe shifts by one.
- Boundary conditions:
  - When N is not a multiple of CHUNK, the top slice is N-(STAGES-1)*CHUNK bits.
  - When CHUNK >= N, STAGES=1 and the block is a single registered adder with latency 1.
  - Wrap-around is modulo 2^N, e.g. all-ones + 1 gives s=0, cout=1.
- Reset mid-operation: in-flight beats are discarded, no partial output is produced, and out_valid drops immediately (async).
- Data registers need no reset beyond the state listed above. The valid bits gate everything.

Test Plan:
- N=33, CHUNK=11, out_ready=1: x=0x0_0000_0001, y=0x1_FFFF_FFFF, sub=0 → after 3 cycles out_valid=1, s=0x0_0000_0000, cout=1, ovf=0. Confirms the carry ripples across all stage boundaries.
- sub=1, x=5, y=7 → s=0x1_FFFF_FFFE, cout=0 (borrow), ovf=0. Then x=0x0_FFFF_FFFF (max positive), y=0x1_FFFF_FFFF (-1), sub=1 → s=0x1_0000_0000, ovf=1.
- Stream 8 back-to-back beats with out_ready=1 → 8 consecutive valid results in order, in_ready held at 1, first result at cycle 3.
- Stall: hold out_ready=0 for 5 cycles with in_valid=1 → in_ready=0 once out_valid=1, s frozen and no beat lost or duplicated. Release out_ready → the remaining beats drain in order.
- Reset: assert rst_n=0 with 2 beats in flight → out_valid=0 and s=0 immediately. After release, no stale result appears and a new beat completes at latency 3.
- Parameter sweep with N=8, CHUNK=3 (STAGES=3, top slice 2 bits) and N=8, CHUNK=8: 200 random x, y, sub each, checked against a reference (x ± y) mod 2^8 with cout and ovf.

Source files
------------

// File: rtl/pipelined_addsub.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_addsub
// Purpose  : N-bit add/subtract, one CHUNK-bit slice per stage, valid/ready
// Revision : 1.0
// ============================================================================
module pipelined_addsub #(
   parameter int N     = 33,
   parameter int CHUNK = 11
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] s,
   output logic         cout,
   output logic         ovf
);

   localparam int STAGES = (N + CHUNK - 1) / CHUNK;
   localparam int LAST   = STAGES - 1;

   logic         w_adv;
   logic         r_v  [STAGES];
   logic         r_c  [STAGES];
   logic [N-1:0] r_x  [STAGES];
   logic [N-1:0] r_yy [STAGES];
   logic [N-1:0] r_s  [STAGES];
   logic         r_ovf;

   // The whole pipe moves as one; a stalled output freezes every stage.
   assign w_adv     = !r_v[LAST] || out_ready;
   assign in_ready  = w_adv;
   assign out_valid = r_v[LAST];
   assign s         = r_s[LAST];
   assign cout      = r_c[LAST];
   assign ovf       = r_ovf;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO = k * CHUNK;
      localparam int W  = (k == LAST) ? (N - LO) : CHUNK;

      logic         w_vi;
      logic         w_ci;
      logic [N-1:0] w_xi;
      logic [N-1:0] w_yi;
      logic [N-1:0] w_si;
      logic [N-1:0] w_sn;
      logic [W:0]   w_slice;

      if (k == 0) begin : g_head
         assign w_vi = in_valid;
         assign w_ci = sub;
         assign w_xi = x;
         assign w_yi = sub ? ~y : y;
         assign w_si = '0;
      end else begin : g_body
         assign w_vi = r_v[k-1];
         assign w_ci = r_c[k-1];
         assign w_xi = r_x[k-1];
         assign w_yi = r_yy[k-1];
         assign w_si = r_s[k-1];
      end

      assign w_slice = {1'b0, w_xi[LO+W-1:LO]} + {1'b0, w_yi[LO+W-1:LO]}
                     + {{W{1'b0}}, w_ci};

      // Lower result slices ride along; this stage fills in its own slice.
      always_comb begin
         w_sn              = w_si;
         w_sn[LO+W-1:LO]   = w_slice[W-1:0];
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_v[k] <= 1'b0;
            r_c[k] <= 1'b0;
            r_s[k] <= '0;
         end else if (w_adv) begin
            r_v[k] <= w_vi;
            r_c[k] <= w_slice[W];
            r_s[k] <= w_sn;
         end
      end

      always_ff @(posedge clk) begin
         if (w_adv) begin
            r_x[k]  <= w_xi;
            r_yy[k] <= w_yi;
         end
      end

      if (k == LAST) begin : g_tail
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_ovf <= 1'b0;
            end else if (w_adv) begin
               r_ovf <= (w_xi[N-1] == w_yi[N-1]) && (w_slice[W-1] != w_xi[N-1]);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
`default_nettype none
// Bench for pipelined_addsub: default 33/11 instance plus 8/3 and 8/8 instances,
// scoreboard queues filled on accept and drained on retire.
module tb_pipelined_addsub;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        d_iv, d_ir, d_ov, d_or, d_sub, d_cout, d_ovf;
   logic [32:0] d_x, d_y, d_s;

   logic        e_iv, e_sub;
   logic        e_or = 1'b1;
   logic [7:0]  e_x, e_y;
   logic        a_ir, a_ov, a_cout, a_ovf;
   logic [7:0]  a_s;
   logic        b_ir, b_ov, b_cout, b_ovf;
   logic [7:0]  b_s;

   int checks = 0;
   int errors = 0;
   int edges  = 0;
   int accn0  = 0;
   int ret0   = 0;
   int acc_edge [3] = '{-100, -100, -100};
   int ret_edge [3] = '{-200, -200, -200};

   logic [34:0] q0 [$];
   logic [34:0] q1 [$];
   logic [34:0] q2 [$];

   always #5 clk = ~clk;

   pipelined_addsub dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(d_iv), .in_ready(d_ir), .x(d_x), .y(d_y),
      .sub(d_sub), .out_valid(d_ov), .out_ready(d_or), .s(d_s), .cout(d_cout), .ovf(d_ovf));

   pipelined_addsub #(.N(8), .CHUNK(3)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(e_iv), .in_ready(a_ir), .x(e_x), .y(e_y),
      .sub(e_sub), .out_valid(a_ov), .out_ready(e_or), .s(a_s), .cout(a_cout), .ovf(a_ovf));

   pipelined_addsub #(.N(8), .CHUNK(8)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(e_iv), .in_ready(b_ir), .x(e_x), .y(e_y),
      .sub(e_sub), .out_valid(b_ov), .out_ready(e_or), .s(b_s), .cout(b_cout), .ovf(b_ovf));

   function automatic logic [34:0] ref_op(input int n, input logic [32:0] a,
                                          input logic [32:0] b, input logic op);
      logic [63:0] m, ua, ub, r;
      logic        sa, sb, ss, c, v;
      m  = (64'd1 << n) - 64'd1;
      ua = {31'd0, a} & m;
      ub = {31'd0, b} & m;
      r  = op ? (ua + (~ub & m) + 64'd1) : (ua + ub);
      c  = r[n];
      sa = ua[n-1];
      sb = ub[n-1];
      ss = r[n-1];
      v  = op ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
      return {v, c, 33'(r & m)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample handshakes at the falling edge, score, then cross the rising edge.
   task automatic cyc();
      logic        acc0, acc1, acc2;
      logic [34:0] e;
      @(negedge clk);
      acc0 = d_iv && d_ir;
      acc1 = e_iv && a_ir;
      acc2 = e_iv && b_ir;
      if (d_ov && d_or) begin
         if (q0.size() == 0) chk("n33_spurious_out", {63'd0, d_ov}, 64'd0);
         else begin
            e = q0.pop_front();
            chk("n33_s", {31'd0, d_s}, {31'd0, e[32:0]});
            chk("n33_cout", {63'd0, d_cout}, {63'd0, e[33]});
            chk("n33_ovf", {63'd0, d_ovf}, {63'd0, e[34]});
            ret0++;
            ret_edge[0] = edges;
         end
      end
      if (a_ov) begin
         if (q1.size() == 0) chk("n8c3_spurious_out", {63'd0, a_ov}, 64'd0);
         else begin
            e = q1.pop_front();
            chk("n8c3_result", {61'd0, a_ovf, a_cout, a_s}, {61'd0, e[34], e[33], e[7:0]});
            ret_edge[1] = edges;
         end
      end
      if (b_ov) begin
         if (q2.size() == 0) chk("n8c8_spurious_out", {63'd0, b_ov}, 64'd0);
         else begin
            e = q2.pop_front();
            chk("n8c8_result", {61'd0, b_ovf, b_cout, b_s}, {61'd0, e[34], e[33], e[7:0]});
            ret_edge[2] = edges;
         end
      end
      if (acc0) begin
         q0.push_back(ref_op(33, d_x, d_y, d_sub));
         acc_edge[0] = edges + 1;
         accn0++;
      end
      if (acc1) begin
         q1.push_back(ref_op(8, {25'd0, e_x}, {25'd0, e_y}, e_sub));
         acc_edge[1] = edges + 1;
      end
      if (acc2) begin
         q2.push_back(ref_op(8, {25'd0, e_x}, {25'd0, e_y}, e_sub));
         acc_edge[2] = edges + 1;
      end
      @(posedge clk);
      edges++;
      #1;
   endtask

   task automatic one_beat(input logic [32:0] a, input logic [32:0] b, input logic op);
      d_x  = a;
      d_y  = b;
      d_sub = op;
      d_iv = 1'b1;
      cyc();
      d_iv = 1'b0;
      for (int i = 0; i < 6 && q0.size() > 0; i++) cyc();
      chk("beat_drained", 64'(q0.size()), 64'd0);
      chk("beat_latency", 64'(ret_edge[0] - acc_edge[0] + 1), 64'd3);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int base_acc, base_ret, k;
      rst_n = 1'b0;
      d_iv = 1'b0; d_or = 1'b1; d_sub = 1'b0; d_x = '0; d_y = '0;
      e_iv = 1'b0; e_sub = 1'b0; e_x = '0; e_y = '0;
      #3;
      chk("reset_out_valid", {63'd0, d_ov}, 64'd0);
      chk("reset_s_cout_ovf", {29'd0, d_ovf, d_cout, d_s}, 64'd0);
      chk("reset_n8_valids", {62'd0, a_ov, b_ov}, 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("reset_in_ready", {63'd0, d_ir}, 64'd1);

      // Carry ripples through every stage boundary; then borrow and signed overflow.
      one_beat(33'h0_0000_0001, 33'h1_FFFF_FFFF, 1'b0);
      one_beat(33'd5, 33'd7, 1'b1);
      one_beat(33'h0_FFFF_FFFF, 33'h1_FFFF_FFFF, 1'b1);
      one_beat(33'h1_0000_0000, 33'h1_0000_0000, 1'b0);

      // Eight back-to-back beats.
      base_ret = ret0;
      for (int i = 0; i < 8; i++) begin
         d_x  = 33'({$urandom(), $urandom()});
         d_y  = 33'({$urandom(), $urandom()});
         d_sub = 1'($urandom());
         d_iv = 1'b1;
         chk("stream_in_ready", {63'd0, d_ir}, 64'd1);
         cyc();
      end
      d_iv = 1'b0;
      for (int i = 0; i < 3; i++) cyc();
      chk("stream_retired", 64'(ret0 - base_ret), 64'd8);
      chk("stream_drained", {63'd0, d_ov}, 64'd0);

      // Stall the consumer for five cycles with input still offered.
      base_acc = accn0;
      base_ret = ret0;
      d_or = 1'b0;
      for (int i = 0; i < 5; i++) begin
         k = accn0 - base_acc;
         d_x  = 33'(k * 1234567 + 11);
         d_y  = 33'(k * 7654321 + 3);
         d_sub = k[0];
         d_iv = 1'b1;
         cyc();
         if (d_ov) begin
            chk("stall_in_ready", {63'd0, d_ir}, 64'd0);
            chk("stall_s_frozen", {31'd0, d_s}, {31'd0, q0[0][32:0]});
         end
      end
      chk("stall_accepted", 64'(accn0 - base_acc), 64'd3);
      d_or = 1'b1;
      for (int i = 0; i < 10 && (accn0 - base_acc) < 6; i++) begin
         k = accn0 - base_acc;
         d_x  = 33'(k * 1234567 + 11);
         d_y  = 33'(k * 7654321 + 3);
         d_sub = k[0];
         d_iv = 1'b1;
         cyc();
      end
      d_iv = 1'b0;
      for (int i = 0; i < 10 && q0.size() > 0; i++) cyc();
      chk("stall_queue_empty", 64'(q0.size()), 64'd0);
      chk("stall_retired", 64'(ret0 - base_ret), 64'd6);

      // Reset with beats in flight, one of them already at the output.
      for (int i = 0; i < 3; i++) begin
         d_x  = 33'h0_1357_9BDF + 33'(i);
         d_y  = 33'h0_0246_8ACE;
         d_sub = 1'b0;
         d_iv = 1'b1;
         cyc();
      end
      d_iv = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset_out_valid", {63'd0, d_ov}, 64'd0);
      chk("midreset_s_cout_ovf", {29'd0, d_ovf, d_cout, d_s}, 64'd0);
      q0.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("postreset_no_stale", {63'd0, d_ov}, 64'd0);
      end
      one_beat(33'h0_1234_5678, 33'h0_0000_0042, 1'b0);

      // Narrow instances: wrap-around beat for latency, then a random sweep.
      e_x = 8'hFF; e_y = 8'h01; e_sub = 1'b0; e_iv = 1'b1;
      cyc();
      e_iv = 1'b0;
      for (int i = 0; i < 4; i++) cyc();
      chk("n8c3_latency", 64'(ret_edge[1] - acc_edge[1] + 1), 64'd3);
      chk("n8c8_latency", 64'(ret_edge[2] - acc_edge[2] + 1), 64'd1);
      for (int i = 0; i < 200; i++) begin
         e_x  = 8'($urandom());
         e_y  = 8'($urandom());
         e_sub = 1'($urandom());
         e_iv = 1'b1;
         cyc();
      end
      e_iv = 1'b0;
      for (int i = 0; i < 4; i++) cyc();
      chk("n8_queues_empty", 64'(q1.size() + q2.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
